// File: rtl/shift_sequencer_pkg.sv
// shift_seq_pkg: shared encodings and default sizes for the multi-cycle shift sequencer
package shift_seq_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int SHAMT_W_DEF = 5;

    localparam logic [1:0] OP_SRL  = 2'b00;
    localparam logic [1:0] OP_SLL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: request/response bundle between the R-type decoder, the sequencer and writeback
interface shift_sequencer_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);

    logic               start;
    logic [1:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   data_in;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;

    modport master (
        output start, op, shamt, data_in,
        input  busy, done, result
    );

    modport slave (
        input  start, op, shamt, data_in,
        output busy, done, result
    );

endinterface

// File: rtl/shift_sequencer_shift_one_stage.sv
// shift_one_stage: combinational 1-bit shifter (srl/sll/sra) built from mux2to1 cells
import shift_seq_pkg::*;

module mux2to1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? b : a;

endmodule

module shift_one_stage #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic             left;
    logic             fill;
    logic [WIDTH-1:0] rgt;
    logic [WIDTH-1:0] lft;

    // reserved op falls through to the logical-right path
    assign left = op == OP_SLL;

    mux2to1 u_fill (.a(1'b0), .b(din[WIDTH-1]), .sel(op == OP_SRA), .y(fill));

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        if (g == WIDTH - 1) begin : g_msb
            assign rgt[g] = fill;
        end else begin : g_rmid
            assign rgt[g] = din[g+1];
        end
        if (g == 0) begin : g_lsb
            assign lft[g] = 1'b0;
        end else begin : g_lmid
            assign lft[g] = din[g-1];
        end
        mux2to1 u_dir (.a(rgt[g]), .b(lft[g]), .sel(left), .y(dout[g]));
    end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: serial shift controller applying one 1-bit stage per cycle with start/busy/done handshake
import shift_seq_pkg::*;

module shift_sequencer #(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    shift_sequencer_if.slave bus
);

    if (SHAMT_W != $clog2(WIDTH)) begin : g_bad_width
        $error("SHAMT_W must equal clog2(WIDTH)");
    end

    state_t             state;
    state_t             state_nx;
    logic [SHAMT_W-1:0] cnt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   sreg;
    logic [WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]   result_q;
    logic               accept;
    logic               last;

    shift_one_stage #(.WIDTH(WIDTH)) u_stage (.op(op_q), .din(sreg), .dout(shifted));

    assign accept = state == IDLE && bus.start;
    assign last   = state == SHIFT && cnt == SHAMT_W'(1);

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // next-state: zero shift skips straight to DONE; DONE always returns to IDLE
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = bus.start ? ((bus.shamt != '0) ? SHIFT : DONE) : IDLE;
            SHIFT:   state_nx = (cnt == SHAMT_W'(1)) ? DONE : SHIFT;
            default: state_nx = IDLE;
        endcase
    end

    // datapath: capture operands on accept, shift while counting down, publish result entering DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= OP_SRL;
            cnt      <= '0;
            sreg     <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q <= bus.op;
            cnt  <= bus.shamt;
            sreg <= bus.data_in;
            if (bus.shamt == '0) result_q <= bus.data_in;
        end else if (state == SHIFT) begin
            sreg <= shifted;
            cnt  <= cnt - SHAMT_W'(1);
            if (last) result_q <= shifted;
        end
    end

    assign bus.busy   = state != IDLE;
    assign bus.done   = state == DONE;
    assign bus.result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: scoreboard-driven self-checking bench for shift_sequencer
module tb_shift_sequencer;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = '0;

    shift_sequencer_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    function automatic logic [31:0] model(input logic [1:0] o, input int s, input logic [31:0] d);
        case (o)
            2'b01:   return d << s;
            2'b10:   return $signed(d) >>> s;
            default: return d >> s;
        endcase
    endfunction

    // one operation: push expected, pulse start, wait (bounded) for done, pop and compare
    task automatic run_op(input logic [1:0] o, input int s, input logic [31:0] d,
                          input logic [31:0] e, input string nm);
        int lat;
        int busy_n;
        logic stable;
        logic [31:0] got;
        exp_q.push_back(e);
        bus.op = o;
        bus.shamt = 5'(s);
        bus.data_in = d;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op = ~o;
        bus.shamt = ~5'(s);
        bus.data_in = ~d;
        lat = 1;
        busy_n = 0;
        stable = 1'b1;
        while (!bus.done && lat < 40) begin
            busy_n += int'(bus.busy);
            if (bus.result !== last_exp) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        busy_n += int'(bus.busy);
        got = exp_q.pop_front();
        n_checks++;
        if (lat !== s + 1) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, required %0d", nm, lat, s + 1);
        end
        n_checks++;
        if (bus.result !== got) begin
            n_fail++;
            $display("FAIL %s result: got %h, required %h", nm, bus.result, got);
        end
        n_checks++;
        if (busy_n !== s + 1) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d, required %0d", nm, busy_n, s + 1);
        end
        n_checks++;
        if (stable !== 1'b1) begin
            n_fail++;
            $display("FAIL %s result_hold_while_shifting: got changed, required %h", nm, last_exp);
        end
        last_exp = got;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s after_done: got busy=%b done=%b, required 0 0", nm, bus.busy, bus.done);
        end
        n_checks++;
        if (bus.result !== got) begin
            n_fail++;
            $display("FAIL %s result_held: got %h, required %h", nm, bus.result, got);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.shamt = '0;
        bus.data_in = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.result} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h, required 0 0 0",
                     bus.busy, bus.done, bus.result);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release_idle: got busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
        last_exp = '0;
    endtask

    task automatic test_srl();
        run_op(2'b00, 4, 32'hF000_0001, 32'h0F00_0000, "srl4");
    endtask

    task automatic test_sra();
        run_op(2'b10, 31, 32'h8000_0000, 32'hFFFF_FFFF, "sra31");
        run_op(2'b00, 31, 32'h8000_0000, 32'h0000_0001, "srl31");
    endtask

    task automatic test_sll_zero();
        run_op(2'b01, 0, 32'h1234_5678, 32'h1234_5678, "sll0");
        run_op(2'b01, 8, 32'h1234_5678, 32'h3456_7800, "sll8");
    endtask

    task automatic test_reserved();
        run_op(2'b11, 4, 32'h8000_0010, 32'h0800_0001, "rsvd4");
    endtask

    // start held high with fresh data every cycle; only IDLE-cycle data may be consumed
    task automatic test_back_to_back(input logic [1:0] o, input int s, input int n);
        int rem = 0;
        int i = 0;
        logic [31:0] d;
        logic [31:0] e;
        while (i < n || rem != 0) begin
            n_checks++;
            if (bus.busy !== (rem != 0)) begin
                n_fail++;
                $display("FAIL b2b_busy: got %b, required %b (cycle %0d)", bus.busy, rem != 0, i);
            end
            n_checks++;
            if (bus.done !== (rem == 1)) begin
                n_fail++;
                $display("FAIL b2b_done: got %b, required %b (cycle %0d)", bus.done, rem == 1, i);
            end
            if (rem == 1) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.result !== e) begin
                    n_fail++;
                    $display("FAIL b2b_result: got %h, required %h", bus.result, e);
                end
                last_exp = e;
            end else begin
                n_checks++;
                if (bus.result !== last_exp) begin
                    n_fail++;
                    $display("FAIL b2b_hold: got %h, required %h", bus.result, last_exp);
                end
            end
            d = $urandom;
            bus.data_in = d;
            bus.op = o;
            bus.shamt = 5'(s);
            bus.start = i < n;
            if (rem == 0) begin
                if (i < n) begin
                    exp_q.push_back(model(o, s, d));
                    rem = s + 1;
                end
            end else begin
                rem--;
            end
            i++;
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic seen;
        bus.op = 2'b00;
        bus.shamt = 5'd10;
        bus.data_in = 32'hF000_0001;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre_busy: got %b, required 1", bus.busy);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_async_flags: got busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
        n_checks++;
        if (bus.result !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_async_result: got %h, required 00000000", bus.result);
        end
        last_exp = '0;
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_done: got activity after release, required none");
        end
        n_checks++;
        if (bus.result !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_result_after: got %h, required 00000000", bus.result);
        end
    endtask

    initial begin
        test_reset();
        test_srl();
        test_sra();
        test_sll_zero();
        test_reserved();
        test_back_to_back(2'b10, 2, 20);
        test_back_to_back(2'b01, 0, 20);
        test_back_to_back(2'b00, 5, 24);
        test_reset_mid();
        run_op(2'b10, 3, 32'h8000_00F0, 32'hF000_001E, "recover_sra3");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
